// File: rtl/mbscore_vic_pkg.sv
// Shared definitions for the MBScore vectored interrupt controller.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
// Contents: cfg_sel register encodings, request FSM states, interrupt id width helper.
package mbscore_vic_pkg;

  // cfg_sel encodings; PEND and ISR are read-only views
  localparam logic [1:0] CFG_MASK = 2'd0;
  localparam logic [1:0] CFG_MODE = 2'd1;
  localparam logic [1:0] CFG_PEND = 2'd2;
  localparam logic [1:0] CFG_ISR  = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } vic_state_e;

  // Width of an interrupt id; a single source still needs one bit
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mbscore_vic_if.sv
// Core/peripheral-facing bundle of the interrupt controller.
// Latency: n/a (wires only).
// Backpressure: int_req is held until int_ack; there is no other stall path.
// Signals: src (interrupt lines), int_en_n/int_ack/eoi (core control),
//   cfg_we/cfg_sel/cfg_wdata/cfg_rdata (config port), int_req/int_id/int_addr (request).
interface mbscore_vic_if
  import mbscore_vic_pkg::*;
#(
  parameter int NUM_SRC    = 8,
  parameter int ADDR_WIDTH = 32
);
  localparam int ID_W = id_w(NUM_SRC);

  logic [NUM_SRC-1:0]    src;
  logic                  int_en_n;
  logic                  int_ack;
  logic                  eoi;
  logic                  cfg_we;
  logic [1:0]            cfg_sel;
  logic [NUM_SRC-1:0]    cfg_wdata;
  logic [NUM_SRC-1:0]    cfg_rdata;
  logic                  int_req;
  logic [ID_W-1:0]       int_id;
  logic [ADDR_WIDTH-1:0] int_addr;

  // controller side
  modport slave (
    input  src, int_en_n, int_ack, eoi, cfg_we, cfg_sel, cfg_wdata,
    output cfg_rdata, int_req, int_id, int_addr
  );

  // core / peripheral side
  modport master (
    output src, int_en_n, int_ack, eoi, cfg_we, cfg_sel, cfg_wdata,
    input  cfg_rdata, int_req, int_id, int_addr
  );

endinterface

// File: rtl/mbscore_vic_prio_enc.sv
// Fixed-priority encoder: index of the lowest set bit plus a valid flag.
// Latency: combinational.
// Backpressure: none.
// Ports: vec_i (request vector), idx_o (lowest set index, 0 when none), vld_o (any bit set).
module mbscore_vic_prio_enc
  import mbscore_vic_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = id_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] vec_i,
  output logic [ID_W-1:0]    idx_o,
  output logic               vld_o
);

  // Scan from the top down so the lowest set index is the last one written
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = ID_W'(i);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mbscore_vic.sv
// Vectored interrupt controller: latches edge/level sources, masks them, resolves fixed priority
// (index 0 highest), requests the core with a handler address and tracks nested in-service levels.
// Latency: src high at edge t -> pending after t -> int_req after t+1.
// Backpressure: int_req/int_id/int_addr are held frozen until int_ack; no back-to-back requests.
// Ports: clk, rst_n (synchronous, active low), bus (mbscore_vic_if.slave).
module mbscore_vic
  import mbscore_vic_pkg::*;
#(
  parameter int                    NUM_SRC         = 8,
  parameter int                    ADDR_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] VEC_BASE        = ADDR_WIDTH'(32'h0000_0100),
  parameter int                    VEC_STRIDE_LOG2 = 4,
  parameter logic [NUM_SRC-1:0]    LEVEL_RST       = '0
) (
  input logic          clk,
  input logic          rst_n,
  mbscore_vic_if.slave bus
);

  localparam int ID_W = id_w(NUM_SRC);

  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] mode_q, mode_d;   // 1 = level, 0 = rising edge
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] isr_q, isr_d;
  logic [NUM_SRC-1:0] src_q;
  vic_state_e         state_q, state_d;
  logic [ID_W-1:0]    int_id_q, int_id_d;

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] below_isr;
  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] ack_oh;
  logic [NUM_SRC-1:0] eoi_oh;
  logic [ID_W-1:0]    elig_idx, isr_idx;
  logic               elig_vld, isr_vld;
  logic               ack_take;

  assign rise = bus.src & ~src_q;

  // Lowest in-service index sets both the preemption threshold and the EOI target
  mbscore_vic_prio_enc #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) u_isr_enc (
    .vec_i (isr_q),
    .idx_o (isr_idx),
    .vld_o (isr_vld)
  );

  always_comb begin
    below_isr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      below_isr[i] = ~isr_vld | (ID_W'(i) < isr_idx);
    end
  end

  assign elig = pend_q & mask_q & below_isr & {NUM_SRC{~bus.int_en_n}};

  mbscore_vic_prio_enc #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) u_elig_enc (
    .vec_i (elig),
    .idx_o (elig_idx),
    .vld_o (elig_vld)
  );

  // int_ack only counts while a request is outstanding
  assign ack_take = (state_q == ST_REQ) & bus.int_ack;
  assign ack_oh   = ack_take ? (NUM_SRC'(1) << int_id_q) : '0;
  assign eoi_oh   = (bus.eoi & isr_vld) ? (NUM_SRC'(1) << isr_idx) : '0;

  // EOI retires the old lowest level before the ack marks the new one
  assign isr_d = (isr_q & ~eoi_oh) | ack_oh;

  always_comb begin
    mask_d = mask_q;
    mode_d = mode_q;
    // Edge bits keep a new rise even when acked in the same cycle; level bits follow src
    pend_d = (mode_q & bus.src) | (~mode_q & ((pend_q & ~ack_oh) | rise));
    if (bus.cfg_we) begin
      case (bus.cfg_sel)
        CFG_MASK: mask_d = bus.cfg_wdata;
        CFG_MODE: begin
          mode_d = bus.cfg_wdata;
          pend_d = pend_d & ~(mode_q ^ bus.cfg_wdata);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    int_id_d = int_id_q;
    case (state_q)
      ST_IDLE: begin
        if (elig_vld) begin
          state_d  = ST_REQ;
          int_id_d = elig_idx;
        end
      end
      ST_REQ: begin
        // Held regardless of mask/int_en_n changes until the core takes it
        if (bus.int_ack) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_q   <= '0;
      mode_q   <= LEVEL_RST;
      pend_q   <= '0;
      isr_q    <= '0;
      src_q    <= '0;
      state_q  <= ST_IDLE;
      int_id_q <= '0;
    end else begin
      mask_q   <= mask_d;
      mode_q   <= mode_d;
      pend_q   <= pend_d;
      isr_q    <= isr_d;
      src_q    <= bus.src;
      state_q  <= state_d;
      int_id_q <= int_id_d;
    end
  end

  assign bus.int_req  = (state_q == ST_REQ);
  assign bus.int_id   = int_id_q;
  assign bus.int_addr = VEC_BASE + (ADDR_WIDTH'(int_id_q) << VEC_STRIDE_LOG2);

  always_comb begin
    bus.cfg_rdata = '0;
    case (bus.cfg_sel)
      CFG_MASK: bus.cfg_rdata = mask_q;
      CFG_MODE: bus.cfg_rdata = mode_q;
      CFG_PEND: bus.cfg_rdata = pend_q;
      CFG_ISR:  bus.cfg_rdata = isr_q;
    endcase
  end

endmodule

// File: tb/tb_mbscore_vic.sv
// Bench for mbscore_vic: directed stimulus pushes expected requests (id, address, cycle) into a
// queue; a negedge monitor pops and compares whenever int_req rises.
// Register state is read back through the cfg port with hand-computed expected values.
module tb_mbscore_vic;
  import mbscore_vic_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mbscore_vic_if #(.NUM_SRC(8), .ADDR_WIDTH(32)) bus ();

  mbscore_vic #(
    .NUM_SRC(8), .ADDR_WIDTH(32), .VEC_BASE(32'h0000_0100),
    .VEC_STRIDE_LOG2(4), .LEVEL_RST(8'h00)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          id;
    logic [31:0] addr;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  logic prev_req    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every rising int_req must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (bus.int_req === 1'b1 && !prev_req) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_req: got id %0d at cycle %0d, expected no request", bus.int_id, cyc);
      end else begin
        e = exp_q.pop_front();
        check("req_id", 32'(bus.int_id), 32'(e.id));
        check("req_addr", bus.int_addr, e.addr);
        check("req_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    prev_req = (bus.int_req === 1'b1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_req(input int id, input logic [31:0] addr, input int dcyc);
    exp_t e;
    e.id   = id;
    e.addr = addr;
    e.cyc  = cyc + dcyc;
    exp_q.push_back(e);
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (bus.int_req !== 1'b1 && n < 20) begin
      step(1);
      n++;
    end
    if (bus.int_req !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: int_req=0 after 20 cycles, expected 1", name);
    end
  endtask

  task automatic pulse_src(input logic [7:0] m);
    bus.src = bus.src | m;
    step(1);
    bus.src = bus.src & ~m;
  endtask

  task automatic do_ack();
    bus.int_ack = 1'b1;
    step(1);
    bus.int_ack = 1'b0;
  endtask

  task automatic do_eoi();
    bus.eoi = 1'b1;
    step(1);
    bus.eoi = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [7:0] data);
    bus.cfg_we    = 1'b1;
    bus.cfg_sel   = sel;
    bus.cfg_wdata = data;
    step(1);
    bus.cfg_we    = 1'b0;
  endtask

  task automatic read(input string name, input logic [1:0] sel, input logic [7:0] req);
    bus.cfg_sel = sel;
    #1;
    check(name, 32'(bus.cfg_rdata), 32'(req));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    bus.src       = '0;
    bus.int_en_n  = 1'b0;
    bus.int_ack   = 1'b0;
    bus.eoi       = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.cfg_sel   = CFG_MASK;
    bus.cfg_wdata = '0;

    // Reset state
    step(3);
    check("rst_int_req", 32'(bus.int_req), 32'h0);
    check("rst_int_id", 32'(bus.int_id), 32'h0);
    check("rst_int_addr", bus.int_addr, 32'h100);
    read("rst_mask", CFG_MASK, 8'h00);
    read("rst_mode", CFG_MODE, 8'h00);
    read("rst_pend", CFG_PEND, 8'h00);
    read("rst_isr", CFG_ISR, 8'h00);
    rst_n = 1'b1;
    step(1);

    // Single edge source, mask 0x04
    cfg_write(CFG_MASK, 8'h04);
    read("mask_04", CFG_MASK, 8'h04);
    expect_req(2, 32'h120, 2);
    pulse_src(8'h04);
    wait_req("wait_id2");
    do_ack();
    read("ack2_isr", CFG_ISR, 8'h04);
    read("ack2_pend", CFG_PEND, 8'h00);
    do_eoi();
    read("eoi2_isr", CFG_ISR, 8'h00);

    // Nesting: id 1 preempts isr[5]; id 6 waits for EOI of 5
    cfg_write(CFG_MASK, 8'hFF);
    expect_req(5, 32'h150, 2);
    pulse_src(8'h20);
    wait_req("wait_id5");
    do_ack();
    read("ack5_isr", CFG_ISR, 8'h20);
    expect_req(1, 32'h110, 2);
    pulse_src(8'h02);
    wait_req("wait_id1");
    do_ack();
    read("nest_isr", CFG_ISR, 8'h22);
    do_eoi();
    read("eoi1_isr", CFG_ISR, 8'h20);
    pulse_src(8'h40);
    step(5);
    check("blocked6_req", 32'(bus.int_req), 32'h0);
    read("blocked6_pend", CFG_PEND, 8'h40);
    expect_req(6, 32'h160, 2);
    do_eoi();
    wait_req("wait_id6");
    do_ack();
    read("ack6_isr", CFG_ISR, 8'h40);
    do_eoi();
    read("eoi6_isr", CFG_ISR, 8'h00);

    // Global disable holds off a pending request
    bus.int_en_n = 1'b1;
    pulse_src(8'h01);
    step(4);
    check("disabled_req", 32'(bus.int_req), 32'h0);
    read("disabled_pend", CFG_PEND, 8'h01);
    expect_req(0, 32'h100, 1);
    bus.int_en_n = 1'b0;
    wait_req("wait_id0_en");
    do_ack();
    do_eoi();
    read("en_isr", CFG_ISR, 8'h00);
    read("en_pend", CFG_PEND, 8'h00);

    // Level source held through ack and EOI re-requests
    cfg_write(CFG_MODE, 8'h08);
    read("mode_08", CFG_MODE, 8'h08);
    expect_req(3, 32'h130, 2);
    bus.src = 8'h08;
    wait_req("wait_lvl3_a");
    do_ack();
    read("lvl_isr", CFG_ISR, 8'h08);
    read("lvl_pend", CFG_PEND, 8'h08);
    step(3);
    check("lvl_blocked_req", 32'(bus.int_req), 32'h0);
    expect_req(3, 32'h130, 2);
    do_eoi();
    wait_req("wait_lvl3_b");
    do_ack();
    bus.src = 8'h00;
    step(1);
    do_eoi();
    read("lvl_end_isr", CFG_ISR, 8'h00);
    read("lvl_end_pend", CFG_PEND, 8'h00);
    cfg_write(CFG_MODE, 8'h00);

    // Same-cycle EOI + ack, with a new edge on the acked source
    expect_req(4, 32'h140, 2);
    pulse_src(8'h10);
    wait_req("wait_id4");
    do_ack();
    read("ack4_isr", CFG_ISR, 8'h10);
    expect_req(2, 32'h120, 2);
    pulse_src(8'h04);
    wait_req("wait_id2_b");
    bus.src     = 8'h04;
    bus.int_ack = 1'b1;
    bus.eoi     = 1'b1;
    step(1);
    bus.int_ack = 1'b0;
    bus.eoi     = 1'b0;
    read("same_cyc_isr", CFG_ISR, 8'h04);
    read("same_cyc_pend", CFG_PEND, 8'h04);
    bus.src = 8'h00;
    step(2);
    check("same_cyc_blocked", 32'(bus.int_req), 32'h0);
    expect_req(2, 32'h120, 2);
    do_eoi();
    wait_req("wait_id2_c");
    do_ack();
    read("repend_pend", CFG_PEND, 8'h00);
    read("repend_isr", CFG_ISR, 8'h04);
    do_eoi();
    read("repend_eoi_isr", CFG_ISR, 8'h00);

    // Reset during a request with src[0] held high
    expect_req(0, 32'h100, 2);
    bus.src = 8'h01;
    wait_req("wait_id0_pre_rst");
    rst_n = 1'b0;
    step(1);
    check("rst_mid_req", 32'(bus.int_req), 32'h0);
    step(2);
    read("rst_mid_mask", CFG_MASK, 8'h00);
    read("rst_mid_isr", CFG_ISR, 8'h00);
    rst_n = 1'b1;
    step(1);
    read("post_rst_pend", CFG_PEND, 8'h01);
    expect_req(0, 32'h100, 2);
    cfg_write(CFG_MASK, 8'hFF);
    wait_req("wait_id0_post_rst");
    do_ack();
    step(6);
    check("post_rst_single", 32'(bus.int_req), 32'h0);
    read("post_rst_pend2", CFG_PEND, 8'h00);
    read("post_rst_isr", CFG_ISR, 8'h01);
    do_eoi();
    bus.src = 8'h00;
    step(2);

    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
